mac_operand_src: RTL and testbench
==================================

# mac_operand_src

Operand transmitter for the multiply-accumulate stream datapath. It fetches two word vectors, A and B, from a single-port word memory and emits them as lockstep `a` and `b` valid/ready streams that feed the MAC engine's operand inputs. One `start` pulse produces exactly `len+1` element pairs, which matches the MAC engine's `reg_len` convention. The block sits between the memory-side interconnect and the MAC engine, inside the same accelerator wrapper.

## Interface
- `MAC_CNT_LEN`, 4096: maximum vector length. Counter width is `$clog2(MAC_CNT_LEN)+1`.
- `ADDR_W`, 32: byte-address width.
- `ap_clk` in 1: the single clock.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle job launch, sampled only in IDLE.
- `base_a` in ADDR_W: byte base address of vector A, word-aligned.
- `base_b` in ADDR_W: byte base address of vector B, word-aligned.
- `len` in $clog2(MAC_CNT_LEN): element count minus 1.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the last pair handshake.
- `mem_req` out 1: read request.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_addr` out ADDR_W: request byte address.
- `mem_rvalid` in 1: read data valid, exactly 1 cycle after `mem_req & mem_gnt`.
- `mem_rdata` in 32: read data.
- `a_TVALID` out 1, `a_TREADY` in 1, `a_TDATA` out 32: A operand stream.
- `b_TVALID` out 1, `b_TREADY` in 1, `b_TDATA` out 32: B operand stream.

## Operation
- The FSM has four states: IDLE, FETCH_A, FETCH_B, DRAIN.
- IDLE:
  - On `start`, latch `base_a`, `base_b` and `len`.
  - Clear the fetch counter `fcnt` and the output counter `ocnt`.
  - Go to FETCH_A.
- FETCH_A:
  - Assert `mem_req` when A-FIFO occupancy plus in-flight A reads is less than the FIFO depth.
  - Address is `base_a + 4*fcnt`.
  - On grant, go to FETCH_B. Otherwise hold the request; the address stays stable while `mem_req` is high.
- FETCH_B:
  - Same credit rule, applied to the B FIFO; address is `base_b + 4*fcnt`.
  - On grant, increment `fcnt`.
  - If `fcnt == len` before the increment, go to DRAIN; otherwise go to FETCH_A.
- Returned data routing:
  - A 1-bit tag, registered at grant, records whether the read was for A or B.
  - When `mem_rvalid` is high, `mem_rdata` is written to the FIFO named by the tag.
- Output streams:
  - `a_TVALID = b_TVALID = !A_empty & !B_empty`.
  - TDATA is the FIFO head, driven from registers. It is never driven combinationally from `mem_rdata`.
  - A pair transfer happens when `a_TVALID & a_TREADY & b_TREADY`. Both FIFOs pop together and `ocnt` increments.
- DRAIN:
  - No requests are issued.
  - When the pair with `ocnt == len` transfers, pulse `done` in the next cycle and go to IDLE.
- Address arithmetic wraps modulo 2^ADDR_W.
- `len = 0` produces exactly one pair.
- `start` while not in IDLE is ignored, and latched parameters do not change.
- Credit accounting covers the simultaneous cases:
  - A grant and a FIFO pop in the same cycle both apply.
  - A write and a pop in the same cycle leave occupancy unchanged.
  - A write into an empty FIFO with no pop makes valid rise in the next cycle.

## Timing
- Reset values:
  - `busy`, `done`, `mem_req`, `a_TVALID` and `b_TVALID` are 0.
  - `mem_addr`, `a_TDATA` and `b_TDATA` are 0.
  - FSM is in IDLE; all counters and FIFOs are empty.
- Reset asserted mid-job aborts immediately. Any `mem_rvalid` arriving after reset is released is discarded.
- With `start` at cycle 0 and `mem_gnt` tied to 1:
  - Cycle 1: `mem_req` for A[0].
  - Cycle 2: `mem_req` for B[0].
  - Cycle 4: first `a_TVALID` and `b_TVALID`.
- Sustained throughput is 1 pair per 2 cycles, limited by the single memory port.
- Valid/ready rules:
  - Once asserted, TVALID stays high and TDATA stays stable until the pair handshake.
  - TVALID never depends combinationally on TREADY.
- `done` is high exactly 1 cycle after the final handshake. `busy` falls in that same cycle.

## Configuration
- `MAC_SRC_DEEP_FIFO_EN`:
  - Defined: each of the A and B FIFOs is 4 entries deep. With `mem_gnt` tied to 1, fetching is never credit-stalled while the consumer is ready.
  - Undefined: each FIFO is 2 entries deep. A ready consumer still sustains the full 1 pair per 2 cycles.
  - Behaviour visible at the ports is identical except for the stall points under backpressure.

## Test plan
- Basic vector job:
  - Stimulus: memory A = {1,2,3,4}, B = {5,6,7,8}, `len=3`, ready and grant always 1.
  - Response: pairs (1,5), (2,6), (3,7), (4,8) in order; first valid at cycle 4; `done` pulses once; exactly 8 requests issued.
- Single-element job:
  - Stimulus: `len=0`.
  - Response: exactly one pair, then `done`; `start` issued while busy produces no second job.
- Consumer backpressure:
  - Stimulus: `a_TREADY` low for 20 cycles mid-job.
  - Response:
    - Issued requests stop once credits are exhausted: 2+2 reads with 2-entry FIFOs, 4+4 with `MAC_SRC_DEEP_FIFO_EN`.
    - TDATA is held stable throughout.
    - No data is lost after ready returns.
- Grant stalls:
  - Stimulus: `mem_gnt` random at 30%.
  - Response: `mem_addr` stays stable while `mem_req` is held; output sequence is unchanged; `done` follows the last pair.
- Address wrap:
  - Stimulus: `base_a = 32'hFFFF_FFF8`, `len=3`.
  - Response: A addresses are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Reset mid-job:
  - Stimulus: assert `ap_rst_n=0` after 3 pairs, then start a new job.
  - Response:
    - All outputs are 0 during reset.
    - A `mem_rvalid` arriving after release is ignored.
    - The new job outputs only its own data.

Source files
------------

// File: rtl/mac_operand_src.sv
`timescale 1ns/1ps
// mac_operand_src: fetches word vectors A and B over one read port and emits them
// as lockstep a/b operand streams. Optional MAC_SRC_DEEP_FIFO_EN: 4-entry FIFOs instead of 2.

module mac_src_fifo #(
  parameter int DEPTH = 2,
  parameter int OCC_W = 2
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             wr,
  input  logic [31:0]      wdata,
  input  logic             pop,
  output logic [31:0]      head,
  output logic [OCC_W-1:0] occ
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][31:0] mem;
  logic [PW-1:0]          wp, rp;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      mem <= '0;
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= wdata;
        wp      <= wp + PW'(1);
      end
      if (pop) rp <= rp + PW'(1);
      if (wr && !pop)      occ <= occ + OCC_W'(1);
      else if (pop && !wr) occ <= occ - OCC_W'(1);
    end
  end

  // Head is a register mux, never a bypass of the write data.
  assign head = mem[rp];
endmodule

module mac_operand_src #(
  parameter int MAC_CNT_LEN = 4096,
  parameter int ADDR_W      = 32
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst_n,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              base_a,
  input  logic [ADDR_W-1:0]              base_b,
  input  logic [$clog2(MAC_CNT_LEN)-1:0] len,
  output logic                           busy,
  output logic                           done,
  output logic                           mem_req,
  input  logic                           mem_gnt,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic                           mem_rvalid,
  input  logic [31:0]                    mem_rdata,
  output logic                           a_TVALID,
  input  logic                           a_TREADY,
  output logic [31:0]                    a_TDATA,
  output logic                           b_TVALID,
  input  logic                           b_TREADY,
  output logic [31:0]                    b_TDATA
);
  localparam int LEN_W = $clog2(MAC_CNT_LEN);
  localparam int CNT_W = LEN_W + 1;
`ifdef MAC_SRC_DEEP_FIFO_EN
  localparam int FIFO_D = 4;
`else
  localparam int FIFO_D = 2;
`endif
  localparam int OCC_W = $clog2(FIFO_D + 1);

  typedef enum logic [1:0] {IDLE, FETCH_A, FETCH_B, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic [ADDR_W-1:0]        ba_q, bb_q, off;
  logic [LEN_W-1:0]         len_q;
  logic [CNT_W-1:0]         fcnt, ocnt;
  logic                     pend, tag_b, done_q;
  logic                     grant, pop, valid, last_fetch, last_pop;
  logic [1:0]               inflight, credit, wr;
  logic [1:0][31:0]         head;
  logic [1:0][OCC_W-1:0]    occ;

  // Index 0 is the A operand, index 1 is B.
  assign inflight[0] = pend & ~tag_b;
  assign inflight[1] = pend &  tag_b;

  for (genvar i = 0; i < 2; i++) begin : g_fifo
    assign wr[i]     = mem_rvalid & inflight[i];
    assign credit[i] = ((OCC_W+1)'(occ[i]) + (OCC_W+1)'(inflight[i])) < (OCC_W+1)'(FIFO_D);

    mac_src_fifo #(.DEPTH(FIFO_D), .OCC_W(OCC_W)) u_fifo (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .wr       (wr[i]),
      .wdata    (mem_rdata),
      .pop      (pop),
      .head     (head[i]),
      .occ      (occ[i])
    );
  end

  assign valid      = (occ[0] != '0) && (occ[1] != '0);
  assign pop        = valid & a_TREADY & b_TREADY;
  assign grant      = mem_req & mem_gnt;
  assign last_fetch = (fcnt == {1'b0, len_q});
  assign last_pop   = (ocnt == {1'b0, len_q});
  assign off        = ADDR_W'({fcnt, 2'b00});

  assign a_TVALID = valid;
  assign b_TVALID = valid;
  assign a_TDATA  = head[0];
  assign b_TDATA  = head[1];
  assign busy     = (state != IDLE);
  assign done     = done_q;

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_addr  = '0;
    case (state)
      IDLE:    if (start) state_nxt = FETCH_A;
      FETCH_A: begin
        mem_req  = credit[0];
        mem_addr = ba_q + off;
        if (grant) state_nxt = FETCH_B;
      end
      FETCH_B: begin
        mem_req  = credit[1];
        mem_addr = bb_q + off;
        if (grant) state_nxt = last_fetch ? DRAIN : FETCH_A;
      end
      DRAIN:   if (pop && last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state  <= IDLE;
      ba_q   <= '0;
      bb_q   <= '0;
      len_q  <= '0;
      fcnt   <= '0;
      ocnt   <= '0;
      pend   <= 1'b0;
      tag_b  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == DRAIN) && pop && last_pop;
      // Read data returns exactly one cycle after the grant; the tag steers it.
      pend   <= grant;
      tag_b  <= (state == FETCH_B);
      if (state == IDLE && start) begin
        ba_q  <= base_a;
        bb_q  <= base_b;
        len_q <= len;
        fcnt  <= '0;
        ocnt  <= '0;
      end else begin
        if (state == FETCH_B && grant) fcnt <= fcnt + CNT_W'(1);
        if (pop)                       ocnt <= ocnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_mac_operand_src.sv
`timescale 1ns/1ps
// Bench for mac_operand_src: directed jobs plus random grant/ready, checked against a
// vector-level reference (expected pair i = mem[base_a+4i], mem[base_b+4i]).
module tb_mac_operand_src;
`ifdef MAC_SRC_DEEP_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 2;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_a = '0, base_b = '0;
  logic [11:0] len = '0;
  logic        busy, done, mem_req;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        a_TVALID, b_TVALID;
  logic        a_TREADY = 1'b1, b_TREADY = 1'b1;
  logic [31:0] a_TDATA, b_TDATA;

  always #5 ap_clk = ~ap_clk;

  mac_operand_src dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .base_a(base_a), .base_b(base_b),
    .len(len), .busy(busy), .done(done), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .a_TVALID(a_TVALID), .a_TREADY(a_TREADY), .a_TDATA(a_TDATA),
    .b_TVALID(b_TVALID), .b_TREADY(b_TREADY), .b_TDATA(b_TDATA)
  );

  int errs = 0, checks = 0, cyc = 0;
  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] got_a[$], got_b[$], req_q[$];
  int gnt_pct = 100, rdy_pct = 100;
  bit hold_a = 0, inject = 0, pend_v = 0;
  logic [31:0] pend_d = '0;
  bit prev_vhold = 0, prev_rhold = 0;
  logic [31:0] prev_ta, prev_tb, prev_addr;
  int hs_cnt, grants, done_cnt, done_cyc, last_hs_cyc, first_vld_cyc, req_first_cyc;
  bit busy_at_done;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_req"},   32'(mem_req), 32'd0);
    chk({tag, "_avld"},  32'(a_TVALID), 32'd0);
    chk({tag, "_bvld"},  32'(b_TVALID), 32'd0);
    chk({tag, "_addr"},  mem_addr, 32'd0);
    chk({tag, "_adata"}, a_TDATA, 32'd0);
    chk({tag, "_bdata"}, b_TDATA, 32'd0);
  endtask

  // One clock cycle: drive the memory/consumer side, sample outputs mid-cycle, advance.
  task automatic step();
    bit hs, g;
    if (inject) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
    end else begin
      mem_rvalid = pend_v;
      mem_rdata  = pend_v ? pend_d : 32'h0;
    end
    mem_gnt  = ($urandom_range(99) < gnt_pct);
    a_TREADY = !hold_a && ($urandom_range(99) < rdy_pct);
    b_TREADY = ($urandom_range(99) < rdy_pct);
    #1;
    if (ap_rst_n) begin
      if (prev_vhold) begin
        chk("tvalid_hold", 32'(a_TVALID), 32'd1);
        chk("a_tdata_stable", a_TDATA, prev_ta);
        chk("b_tdata_stable", b_TDATA, prev_tb);
      end
      if (prev_rhold) begin
        chk("req_hold", 32'(mem_req), 32'd1);
        chk("addr_stable", mem_addr, prev_addr);
      end
      chk("b_vld_eq_a_vld", 32'(b_TVALID), 32'(a_TVALID));
    end
    hs = ap_rst_n && a_TVALID && a_TREADY && b_TREADY;
    g  = ap_rst_n && mem_req && mem_gnt;
    if (a_TVALID && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (mem_req && req_first_cyc < 0)  req_first_cyc = cyc;
    if (hs) begin
      got_a.push_back(a_TDATA);
      got_b.push_back(b_TDATA);
      hs_cnt++;
      last_hs_cyc = cyc;
    end
    if (g) begin
      req_q.push_back(mem_addr);
      grants++;
    end
    pend_v = g;
    pend_d = rd(mem_addr);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    prev_vhold = ap_rst_n && a_TVALID && !hs;
    prev_ta    = a_TDATA;
    prev_tb    = b_TDATA;
    prev_rhold = ap_rst_n && mem_req && !mem_gnt;
    prev_addr  = mem_addr;
    @(negedge ap_clk);
    cyc++;
  endtask

  task automatic clear_obs();
    got_a.delete(); got_b.delete(); req_q.delete();
    hs_cnt = 0; grants = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
    first_vld_cyc = -1; req_first_cyc = -1; busy_at_done = 1'b1;
  endtask

  task automatic run_job(input string nm, input logic [31:0] ba, input logic [31:0] bb,
                         input logic [11:0] ln, input int gp, input int rp,
                         input int bp_at, input int bp_len, input int restart_at);
    int c0, n;
    bit fin;
    clear_obs();
    gnt_pct = gp; rdy_pct = rp;
    base_a = ba; base_b = bb; len = ln; start = 1'b1;
    c0 = cyc;
    step();
    start = 1'b0;
    base_a = $urandom & ~32'h3; base_b = $urandom & ~32'h3; len = 12'($urandom);
    chk({nm, "_busy_rise"}, 32'(busy), 32'd1);
    fin = 0;
    for (int rel = 1; rel < 3000 && !fin; rel++) begin
      start = (rel == restart_at);
      if (bp_len > 0 && rel == bp_at + bp_len) begin
        chk({nm, "_bp_outstanding"}, 32'(grants - 2 * hs_cnt), 32'(2 * DEPTH));
        chk({nm, "_bp_req_idle"}, 32'(mem_req), 32'd0);
      end
      hold_a = (bp_len > 0) && rel >= bp_at && rel < bp_at + bp_len;
      step();
      if (done_cnt > 0) fin = 1;
    end
    start = 1'b0; hold_a = 0;
    chk({nm, "_done_seen"}, 32'(fin), 32'd1);
    repeat (6) step();
    chk({nm, "_pairs"}, 32'(hs_cnt), 32'(ln) + 32'd1);
    chk({nm, "_reqs"}, 32'(grants), 2 * (32'(ln) + 32'd1));
    chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({nm, "_done_time"}, 32'(done_cyc), 32'(last_hs_cyc + 1));
    chk({nm, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    n = (hs_cnt < int'(ln) + 1) ? hs_cnt : int'(ln) + 1;
    for (int i = 0; i < n; i++) begin
      chk({nm, "_a_data"}, got_a[i], rd(ba + 32'(4 * i)));
      chk({nm, "_b_data"}, got_b[i], rd(bb + 32'(4 * i)));
    end
    n = (req_q.size() < 2 * (int'(ln) + 1)) ? req_q.size() : 2 * (int'(ln) + 1);
    for (int i = 0; i < n; i++)
      chk({nm, "_addr"}, req_q[i], ((i % 2) == 0 ? ba : bb) + 32'(4 * (i / 2)));
    if (gp == 100 && rp == 100) begin
      chk({nm, "_first_req_cyc"}, 32'(req_first_cyc - c0), 32'd1);
      chk({nm, "_first_vld_cyc"}, 32'(first_vld_cyc - c0), 32'd4);
    end
  endtask

  initial begin
    repeat (3) @(negedge ap_clk);
    chk_all_zero("reset");
    ap_rst_n = 1'b1;
    step(); step();

    for (int i = 0; i < 4; i++) begin
      mem_img[32'h100 + 32'(4 * i)] = 32'(i + 1);
      mem_img[32'h200 + 32'(4 * i)] = 32'(i + 5);
    end
    run_job("basic", 32'h100, 32'h200, 12'd3, 100, 100, 0, 0, 0);
    if (got_a.size() == 4) begin
      chk("basic_last_a", got_a[3], 32'd4);
      chk("basic_last_b", got_b[3], 32'd8);
    end

    run_job("single", 32'h300, 32'h400, 12'd0, 100, 100, 0, 0, 2);
    run_job("backpressure", 32'h1000, 32'h2000, 12'd15, 100, 100, 6, 20, 0);
    run_job("gnt_stall", 32'h3000, 32'h5000, 12'd11, 30, 100, 0, 0, 0);
    run_job("addr_wrap", 32'hFFFF_FFF8, 32'h0000_8000, 12'd3, 100, 100, 0, 0, 0);
    if (req_q.size() >= 8) begin
      chk("wrap_a2", req_q[4], 32'h0000_0000);
      chk("wrap_a3", req_q[6], 32'h0000_0004);
    end

    // Reset in the middle of a job, stray read data right after release.
    clear_obs();
    gnt_pct = 100; rdy_pct = 100;
    base_a = 32'h6000; base_b = 32'h7000; len = 12'd15; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 50 && hs_cnt < 3; k++) step();
    chk("mid_pairs_before_rst", 32'(hs_cnt), 32'd3);
    ap_rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    step(); step();
    chk_all_zero("mid_rst_hold");
    ap_rst_n = 1'b1;
    inject = 1;
    step();
    inject = 0;
    repeat (3) step();
    chk("post_rst_vld", 32'(a_TVALID), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    run_job("post_rst", 32'h6100, 32'h7100, 12'd4, 100, 100, 0, 0, 0);

    for (int j = 0; j < 6; j++)
      run_job("rand", $urandom & ~32'h3, $urandom & ~32'h3, 12'($urandom_range(20)),
              $urandom_range(30, 100), $urandom_range(40, 100), 0, 0, 3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
